// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and helpers for the ID-stage hazard scoreboard.
//   lat_class_e : latency class carried by an instruction in IF/ID
//   lat_of()    : scoreboard load value for a latency class
package hazard_pkg;

    typedef enum logic [1:0] {
        LC_ALU  = 2'd0,
        LC_LOAD = 2'd1,
        LC_MUL  = 2'd2,
        LC_RSVD = 2'd3
    } lat_class_e;

    // Cycles a consumer placed directly behind an instruction of this class
    // must wait. The reserved encoding behaves like an ALU op.
    function automatic int unsigned lat_of(input lat_class_e cls,
                                           input int unsigned load_lat,
                                           input int unsigned mul_lat);
        case (cls)
            LC_LOAD: lat_of = load_lat;
            LC_MUL:  lat_of = mul_lat;
            default: lat_of = 0;
        endcase
    endfunction

endpackage

// File: rtl/hazard_scoreboard_sb_entry.sv
// One scoreboard slot: a down-counter holding the number of cycles until the
// pending write to its register can be consumed.
//   clk, rst : clock, synchronous active-high reset
//   set      : load set_val (takes priority over the decrement)
//   set_val  : latency to load
//   busy     : current count, nonzero while the write is pending
module hazard_sb_entry #(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          set,
    input  logic [CW-1:0] set_val,
    output logic [CW-1:0] busy
);

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else if (set) begin
            busy <= set_val;
        end else if (busy != '0) begin
            busy <= busy - CW'(1);
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard unit. Tracks pending register writes from loads and
// multi-cycle multiplies, stalls RAW/WAW/structural hazards, gives a taken
// branch in EX priority over any stall, and counts stall cycles.
//   clk, rst           : clock, synchronous active-high reset
//   id_valid .. id_lat_class : decoded instruction in IF/ID
//   ex_branch_taken    : taken branch/jump resolved in EX
//   stall              : hold PC and IF/ID, bubble ID/EX
//   pc_we, if_id_we    : PC and IF/ID write enables
//   if_id_flush        : clear IF/ID to NOP
//   id_ex_bubble       : insert NOP into ID/EX
//   stall_cnt          : saturating count of stall cycles since reset
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NREG          = 32,
    parameter int LOAD_LAT      = 1,
    parameter int MUL_LAT       = 3,
    parameter int MUL_PIPELINED = 0,
    parameter int STALL_CNT_W   = 16,
    localparam int AW           = $clog2(NREG)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    input  logic [AW-1:0]          id_rs1,
    input  logic [AW-1:0]          id_rs2,
    input  logic                   id_rs1_used,
    input  logic                   id_rs2_used,
    input  logic [AW-1:0]          id_rd,
    input  logic                   id_reg_write,
    input  logic [1:0]             id_lat_class,
    input  logic                   ex_branch_taken,
    output logic                   stall,
    output logic                   pc_we,
    output logic                   if_id_we,
    output logic                   if_id_flush,
    output logic                   id_ex_bubble,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam int MAXL = (LOAD_LAT > MUL_LAT) ? LOAD_LAT : MUL_LAT;
    localparam int CW   = (MAXL < 1) ? 1 : $clog2(MAXL + 1);
    localparam logic [CW-1:0] MUL_BUSY_INIT = CW'(MUL_LAT - 1);

    lat_class_e    cls;
    logic [CW-1:0] lat_id;
    logic [CW-1:0] cnt [NREG];
    logic [CW-1:0] mul_busy;
    logic          raw, waw, struct_haz, hazard, issue;

    assign cls    = lat_class_e'(id_lat_class);
    assign lat_id = CW'(lat_of(cls, LOAD_LAT, MUL_LAT));

    // x0 is hardwired, so its slot never holds a pending write.
    assign cnt[0] = '0;

    for (genvar r = 1; r < NREG; r++) begin : g_sb
        logic set_r;
        assign set_r = issue && id_reg_write && (id_rd == AW'(r));
        hazard_sb_entry #(.CW(CW)) u_entry (
            .clk     (clk),
            .rst     (rst),
            .set     (set_r),
            .set_val (lat_id),
            .busy    (cnt[r])
        );
    end

    assign raw = id_valid &&
                 ((id_rs1_used && (id_rs1 != '0) && (cnt[id_rs1] != '0)) ||
                  (id_rs2_used && (id_rs2 != '0) && (cnt[id_rs2] != '0)));

    // A younger write may not land before an older pending write to the same
    // register; equal or shorter remaining time is safe.
    assign waw = id_valid && id_reg_write && (id_rd != '0) && (cnt[id_rd] > lat_id);

    assign struct_haz = id_valid && (cls == LC_MUL) && (MUL_PIPELINED == 0) &&
                        (mul_busy != '0);

    assign hazard = raw || waw || struct_haz;

    // Reset outranks the branch flush, which outranks a stall.
    always_comb begin
        stall        = 1'b0;
        pc_we        = 1'b1;
        if_id_we     = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        if (rst || ex_branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (hazard) begin
            stall        = 1'b1;
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            id_ex_bubble = 1'b1;
        end
    end

    assign issue = id_valid && !stall && !ex_branch_taken && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            mul_busy <= '0;
        end else if (issue && (cls == LC_MUL)) begin
            mul_busy <= MUL_BUSY_INIT;
        end else if (mul_busy != '0) begin
            mul_busy <= mul_busy - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + STALL_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: two instances (classic load-use with a
// blocking 3-cycle MUL, and a 3-cycle load with a long pipelined MUL) share
// one directed stimulus stream. A timestamp model predicts all outputs every
// cycle; literal checks pin the scenarios worked out by hand.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rst_v = 1'b1;
    logic       id_valid = 1'b0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic       id_rs1_used = 1'b0, id_rs2_used = 1'b0, id_reg_write = 1'b0;
    logic [1:0] id_lat_class = '0;
    logic       ex_branch_taken = 1'b0;

    logic        stall_a, pc_we_a, if_id_we_a, if_id_flush_a, id_ex_bubble_a;
    logic        stall_b, pc_we_b, if_id_we_b, if_id_flush_b, id_ex_bubble_b;
    logic [15:0] stall_cnt_a, stall_cnt_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.NREG(32), .LOAD_LAT(1), .MUL_LAT(3), .MUL_PIPELINED(0),
                        .STALL_CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_lat_class(id_lat_class),
        .ex_branch_taken(ex_branch_taken), .stall(stall_a), .pc_we(pc_we_a),
        .if_id_we(if_id_we_a), .if_id_flush(if_id_flush_a),
        .id_ex_bubble(id_ex_bubble_a), .stall_cnt(stall_cnt_a));

    hazard_scoreboard #(.NREG(32), .LOAD_LAT(3), .MUL_LAT(31), .MUL_PIPELINED(1),
                        .STALL_CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_lat_class(id_lat_class),
        .ex_branch_taken(ex_branch_taken), .stall(stall_b), .pc_we(pc_we_b),
        .if_id_we(if_id_we_b), .if_id_flush(if_id_flush_b),
        .id_ex_bubble(id_ex_bubble_b), .stall_cnt(stall_cnt_b));

    // Model: each register remembers the first cycle at which its pending
    // result is consumable; the MUL unit remembers when it is free again.
    int     LL [2] = '{1, 3};
    int     ML [2] = '{3, 31};
    int     MP [2] = '{0, 1};
    longint avail [2][32];
    longint mul_free [2];
    int     scnt [2];
    longint cyc = 0;

    initial begin
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 32; r++) avail[k][r] = 0;
            mul_free[k] = 0;
            scnt[k] = 0;
        end
    end

    function automatic int lat(input int k, input logic [1:0] c);
        if (c == 2'd1) return LL[k];
        if (c == 2'd2) return ML[k];
        return 0;
    endfunction

    function automatic void model_out(input int k, output logic st, output logic pw,
                                      output logic iw, output logic fl, output logic bb);
        logic raw, waw, sh, hz;
        raw = id_valid && ((id_rs1_used && id_rs1 != 0 && cyc < avail[k][id_rs1]) ||
                           (id_rs2_used && id_rs2 != 0 && cyc < avail[k][id_rs2]));
        waw = id_valid && id_reg_write && id_rd != 0 &&
              (avail[k][id_rd] - cyc) > longint'(lat(k, id_lat_class));
        sh  = id_valid && id_lat_class == 2'd2 && MP[k] == 0 && cyc < mul_free[k];
        hz  = raw || waw || sh;
        if (rst || ex_branch_taken) begin
            st = 0; pw = 1; iw = 1; fl = 1; bb = 1;
        end else begin
            st = hz; pw = !hz; iw = !hz; fl = 0; bb = hz;
        end
    endfunction

    function automatic void model_update();
        logic st, pw, iw, fl, bb;
        for (int k = 0; k < 2; k++) begin
            model_out(k, st, pw, iw, fl, bb);
            if (rst) begin
                for (int r = 0; r < 32; r++) avail[k][r] = 0;
                mul_free[k] = 0;
                scnt[k] = 0;
            end else begin
                if (st && scnt[k] < 65535) scnt[k] = scnt[k] + 1;
                if (id_valid && !st && !ex_branch_taken) begin
                    if (id_reg_write && id_rd != 0)
                        avail[k][id_rd] = cyc + 1 + longint'(lat(k, id_lat_class));
                    if (id_lat_class == 2'd2) mul_free[k] = cyc + longint'(ML[k]);
                end
            end
        end
        cyc = cyc + 1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_update();
    end

    initial forever begin
        logic st, pw, iw, fl, bb;
        @(negedge clk);
        model_out(0, st, pw, iw, fl, bb);
        chk("m_stall_a", 32'(stall_a), 32'(st));
        chk("m_pc_we_a", 32'(pc_we_a), 32'(pw));
        chk("m_if_id_we_a", 32'(if_id_we_a), 32'(iw));
        chk("m_flush_a", 32'(if_id_flush_a), 32'(fl));
        chk("m_bubble_a", 32'(id_ex_bubble_a), 32'(bb));
        chk("m_stall_cnt_a", 32'(stall_cnt_a), 32'(scnt[0]));
        model_out(1, st, pw, iw, fl, bb);
        chk("m_stall_b", 32'(stall_b), 32'(st));
        chk("m_pc_we_b", 32'(pc_we_b), 32'(pw));
        chk("m_if_id_we_b", 32'(if_id_we_b), 32'(iw));
        chk("m_flush_b", 32'(if_id_flush_b), 32'(fl));
        chk("m_bubble_b", 32'(id_ex_bubble_b), 32'(bb));
        chk("m_stall_cnt_b", 32'(stall_cnt_b), 32'(scnt[1]));
    end

    task automatic step(input logic v, input logic [4:0] r1, input logic u1,
                        input logic [4:0] r2, input logic u2, input logic [4:0] rd,
                        input logic we, input logic [1:0] cls, input logic br);
        @(posedge clk);
        #1;
        rst = rst_v; id_valid = v; id_rs1 = r1; id_rs1_used = u1; id_rs2 = r2;
        id_rs2_used = u2; id_rd = rd; id_reg_write = we; id_lat_class = cls;
        ex_branch_taken = br;
        @(negedge clk);
        #1;
    endtask

    task automatic nop();                  step(0, 0, 0, 0, 0, 0, 0, 2'd0, 0); endtask
    task automatic idle(input int n);      for (int i = 0; i < n; i++) nop(); endtask
    task automatic load(input logic [4:0] rd, input logic [4:0] r1);
        step(1, r1, 1, 0, 0, rd, 1, 2'd1, 0);
    endtask
    task automatic alu(input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2);
        step(1, r1, 1, r2, 1, rd, 1, 2'd0, 0);
    endtask
    task automatic mul(input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2);
        step(1, r1, 1, r2, 1, rd, 1, 2'd2, 0);
    endtask

    initial begin
        // reset state
        rst_v = 1; nop(); nop();
        chk("rst_stall", 32'(stall_a), 32'd0);
        chk("rst_pc_we", 32'(pc_we_a), 32'd1);
        chk("rst_if_id_we", 32'(if_id_we_a), 32'd1);
        chk("rst_flush", 32'(if_id_flush_a), 32'd1);
        chk("rst_bubble", 32'(id_ex_bubble_a), 32'd1);
        chk("rst_stall_cnt", 32'(stall_cnt_a), 32'd0);
        rst_v = 0;

        // load-use, LOAD_LAT=1
        load(5, 1);      chk("t1_load", 32'(stall_a), 32'd0);
        alu(6, 5, 1);    chk("t1_use_stall", 32'(stall_a), 32'd1);
                         chk("t1_use_pc_we", 32'(pc_we_a), 32'd0);
                         chk("t1_use_bubble", 32'(id_ex_bubble_a), 32'd1);
        alu(6, 5, 1);    chk("t1_release", 32'(stall_a), 32'd0);
                         chk("t1_release_pc_we", 32'(pc_we_a), 32'd1);
                         chk("t1_cnt_a", 32'(stall_cnt_a), 32'd1);
        idle(40);

        // LOAD_LAT=3 with one instruction in between
        chk("t2_cnt_b0", 32'(stall_cnt_b), 32'd2);
        load(7, 1);
        step(1, 0, 0, 0, 0, 0, 0, 2'd0, 0);
        alu(9, 7, 0);    chk("t2_stall1", 32'(stall_b), 32'd1);
        alu(9, 7, 0);    chk("t2_stall2", 32'(stall_b), 32'd1);
        alu(9, 7, 0);    chk("t2_release", 32'(stall_b), 32'd0);
                         chk("t2_cnt_b", 32'(stall_cnt_b), 32'd4);
                         chk("t2_a_nostall_cnt", 32'(stall_cnt_a), 32'd1);

        // WAW behind a MUL, then back-to-back MULs on a blocking unit
        mul(8, 1, 2);    chk("t3_mul", 32'(stall_a), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0, 0, 8, 1, 2'd0, 0);
            chk("t3_waw_stall", 32'(stall_a), 32'd1);
        end
        step(1, 0, 0, 0, 0, 8, 1, 2'd0, 0);
        chk("t3_waw_release", 32'(stall_a), 32'd0);
        mul(9, 1, 2);    chk("t3_mul2", 32'(stall_a), 32'd0);
        mul(10, 1, 2);   chk("t3_struct1", 32'(stall_a), 32'd1);
        mul(10, 1, 2);   chk("t3_struct2", 32'(stall_a), 32'd1);
        mul(10, 1, 2);   chk("t3_struct_release", 32'(stall_a), 32'd0);
        idle(40);

        // load-use coinciding with a taken branch: the killed load must not
        // mark x12 pending
        load(5, 1);
        step(1, 5, 1, 0, 0, 12, 1, 2'd1, 1);
        chk("t4_stall", 32'(stall_a), 32'd0);
        chk("t4_flush", 32'(if_id_flush_a), 32'd1);
        chk("t4_bubble", 32'(id_ex_bubble_a), 32'd1);
        chk("t4_pc_we", 32'(pc_we_a), 32'd1);
        alu(13, 12, 5);  chk("t4_after", 32'(stall_a), 32'd0);
                         chk("t4_after_flush", 32'(if_id_flush_a), 32'd0);

        // x0 and unused sources
        load(0, 1);
        alu(14, 0, 0);   chk("t5_x0", 32'(stall_a), 32'd0);
        load(13, 1);
        step(1, 1, 1, 13, 0, 14, 1, 2'd0, 0);
        chk("t5_rs2_unused", 32'(stall_a), 32'd0);
        idle(40);

        // reset in the middle of a stall
        mul(8, 1, 2);
        alu(9, 8, 0);    chk("t6_pre_stall", 32'(stall_a), 32'd1);
        rst_v = 1;
        alu(9, 8, 0);    chk("t6_rst_stall", 32'(stall_a), 32'd0);
                         chk("t6_rst_flush", 32'(if_id_flush_a), 32'd1);
        rst_v = 0;
        alu(9, 8, 0);    chk("t6_post_stall", 32'(stall_a), 32'd0);
                         chk("t6_post_cnt_a", 32'(stall_cnt_a), 32'd0);
                         chk("t6_post_cnt_b", 32'(stall_cnt_b), 32'd0);

        // saturate the perf counter of the long-latency instance
        for (int i = 0; i < 67800; i++) mul(10, 10, 0);
        chk("t6_sat", 32'(stall_cnt_b), 32'h0000FFFF);
        for (int i = 0; i < 4; i++) mul(10, 10, 0);
        chk("t6_sat_hold", 32'(stall_cnt_b), 32'h0000FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
